keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Responder-side model of the 4x4 Pmod keypad: the device end of the col-drive/row-sense
//  interface that keypad_decoder scans. Accepts key-press commands over a valid/ready
//  handshake and presents the matching contact closure on the row lines, with optional bounce.
//  Used for on-board self-test (loopback through the keypad header) and as a bench stimulus.
// PARAMETERS
//  BOUNCE_CYC   625_000    cycles of contact bounce at press and at release (0 = clean edges)
//  TOGGLE_CYC   12_500     cycles between bounce toggle decisions (>=1)
//  HOLD_CYC     6_250_000  cycles the contact is held solidly closed
//  GAP_CYC      6_250_000  cycles of guaranteed open contact after release before next command
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  col        in   4  column drive from scanner, active-low (keypad[3:0])
//  row        out  4  row sense to scanner, active-low, idle 4'hF (keypad[7:4])
//  cmd_valid  in   1  command present
//  cmd_key    in   4  hex key code to press
//  cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
//  contact    out  1  registered: 1 = switch currently closed
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse on GAP->IDLE transition
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, contact=0, done=0, key latch=0, LFSR=16'hACE1;
//   row=4'hF, cmd_ready=1, busy=0.
//  Key map (code -> row,col): 1:0,0 2:0,1 3:0,2 A:0,3 | 4:1,0 5:1,1 6:1,2 B:1,3
//   7:2,0 8:2,1 9:2,2 C:2,3 | 0:3,0 F:3,1 E:3,2 D:3,3. Latched at accept; cmd_key ignored after.
//  Row output, combinational from col and registered contact/key (zero latency col->row):
//   row = (contact & ~col[kc]) ? ~(4'b1 << kr) : 4'hF. Other driven-low columns have no effect.
//  FSM, one down-counter (width from largest param), reloaded on every transition:
//   IDLE    : accept -> PRESS_B (BOUNCE_CYC>0) else HOLD; contact=0.
//   PRESS_B : every TOGGLE_CYC cycles contact <= LFSR[0], LFSR advances (x^16+x^14+x^13+x^11+1);
//             after BOUNCE_CYC cycles -> HOLD.
//   HOLD    : contact=1 for HOLD_CYC cycles -> REL_B (BOUNCE_CYC>0) else GAP.
//   REL_B   : same toggling as PRESS_B for BOUNCE_CYC cycles -> GAP.
//   GAP     : contact=0 for GAP_CYC cycles -> IDLE, done=1 for that one cycle.
//  Contact changes take effect the cycle after the FSM transition (registered).
//  Accept cycle: contact 0; first closure visible the cycle after entering HOLD (clean) or
//   at first toggle with LFSR[0]=1 (bounce).
//  Back-to-back: cmd_valid held high -> next accept in the cycle IDLE is re-entered (done cycle).
//  cmd_valid low in IDLE: no change. cmd_valid during busy: ignored, not queued.
//  Reset mid-press: contact drops and row=4'hF asynchronously; command is lost, no done.
//  Counter is a down-counter loaded with PARAM-1; zero-valued HOLD/GAP treated as 1 cycle.
// TESTING
//  1 Clean press (BOUNCE_CYC=0, HOLD=8, GAP=4), key 5, col=4'b1101 -> row=4'b1101 for exactly
//    8 cycles, row=4'hF with col=4'b1110 throughout; done pulses 12 cycles after HOLD entry.
//  2 All 16 codes, walking-zero col scan each cycle -> exactly one row low, only when col[kc]=0,
//    matching map table (e.g. key D: col=4'b0111 -> row=4'b0111).
//  3 Bounce (BOUNCE=20, TOGGLE=4) -> contact changes only on 4-cycle boundaries in bounce
//    windows, solid 1 in HOLD, solid 0 in GAP; sequence matches LFSR reference model.
//  4 cmd_valid held with keys 1 then 2 -> second accept on done cycle; cmd_ready=0 while busy;
//    mid-busy key change to 9 has no effect on row.
//  5 rst asserted in HOLD -> row=4'hF same cycle, contact=0, busy=0, cmd_ready=1, no done pulse.
//  6 Loopback with keypad_decoder (scaled params) -> decode_out equals each pressed code and
//    is_a_key_pressed rises once per command despite bounce.

Source files
------------

// File: rtl/keypad_emulator.sv
// Device end of the 4x4 keypad col-drive/row-sense interface.
// Takes key-press commands and presents the contact closure on the row lines, with optional bounce.
module keypad_emulator #(
    parameter int BOUNCE_CYC = 625_000,
    parameter int TOGGLE_CYC = 12_500,
    parameter int HOLD_CYC   = 6_250_000,
    parameter int GAP_CYC    = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic       contact,
    output logic       busy,
    output logic       done
);

    localparam int MAX_BH = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
    localparam int MAXP   = (MAX_BH > GAP_CYC) ? MAX_BH : GAP_CYC;
    localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam int TW     = (TOGGLE_CYC > 1) ? $clog2(TOGGLE_CYC) : 1;

    localparam logic [CW-1:0] LD_BOUNCE = CW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam logic [CW-1:0] LD_HOLD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CW-1:0] LD_GAP    = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] LD_TOG    = TW'((TOGGLE_CYC > 0) ? TOGGLE_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_B,
        S_HOLD,
        S_REL_B,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tog_q, tog_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            contact_q, contact_d;
    logic            done_q, done_d;
    logic [3:0]      key_q, key_d;

    logic            cnt_zero;
    logic            tog_zero;
    logic            lfsr_fb;
    logic [1:0]      kr;
    logic [1:0]      kc;

    assign cnt_zero = (cnt_q == '0);
    assign tog_zero = (tog_q == '0);
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - 1'b1;
        tog_d     = tog_zero ? LD_TOG : tog_q - 1'b1;
        lfsr_d    = lfsr_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        key_d     = key_q;
        case (state_q)
            S_IDLE: begin
                contact_d = 1'b0;
                tog_d     = LD_TOG;
                if (cmd_valid) begin
                    key_d = cmd_key;
                    if (BOUNCE_CYC > 0) begin
                        state_d = S_PRESS_B;
                        cnt_d   = LD_BOUNCE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = LD_HOLD;
                    end
                end
            end
            S_PRESS_B: begin
                if (tog_zero) begin
                    contact_d = lfsr_q[0];
                    lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
                end
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                contact_d = 1'b1;
                tog_d     = LD_TOG;
                if (cnt_zero) begin
                    if (BOUNCE_CYC > 0) begin
                        state_d = S_REL_B;
                        cnt_d   = LD_BOUNCE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = LD_GAP;
                    end
                end
            end
            S_REL_B: begin
                if (tog_zero) begin
                    contact_d = lfsr_q[0];
                    lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
                end
                if (cnt_zero) begin
                    state_d = S_GAP;
                    cnt_d   = LD_GAP;
                end
            end
            S_GAP: begin
                contact_d = 1'b0;
                if (cnt_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                contact_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tog_q     <= '0;
            lfsr_q    <= 16'hACE1;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            key_q     <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            lfsr_q    <= lfsr_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            key_q     <= key_d;
        end
    end

    // Pmod keypad layout: key code -> (row, column)
    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        case (key_q)
            4'h1: begin kr = 2'd0; kc = 2'd0; end
            4'h2: begin kr = 2'd0; kc = 2'd1; end
            4'h3: begin kr = 2'd0; kc = 2'd2; end
            4'hA: begin kr = 2'd0; kc = 2'd3; end
            4'h4: begin kr = 2'd1; kc = 2'd0; end
            4'h5: begin kr = 2'd1; kc = 2'd1; end
            4'h6: begin kr = 2'd1; kc = 2'd2; end
            4'hB: begin kr = 2'd1; kc = 2'd3; end
            4'h7: begin kr = 2'd2; kc = 2'd0; end
            4'h8: begin kr = 2'd2; kc = 2'd1; end
            4'h9: begin kr = 2'd2; kc = 2'd2; end
            4'hC: begin kr = 2'd2; kc = 2'd3; end
            4'h0: begin kr = 2'd3; kc = 2'd0; end
            4'hF: begin kr = 2'd3; kc = 2'd1; end
            4'hE: begin kr = 2'd3; kc = 2'd2; end
            4'hD: begin kr = 2'd3; kc = 2'd3; end
            default: begin kr = 2'd0; kc = 2'd0; end
        endcase
    end

    assign row       = (contact_q & ~col[kc]) ? ~(4'b0001 << kr) : 4'hF;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign contact   = contact_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a clean-edge instance and a bouncing instance
// driven by directed steps, with expected outputs queued ahead of sampling.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       c_rst, c_valid, c_ready, c_contact, c_busy, c_done;
    logic [3:0] c_col, c_row, c_key;
    logic       b_rst, b_valid, b_ready, b_contact, b_busy, b_done;
    logic [3:0] b_col, b_row, b_key;

    keypad_emulator #(
        .BOUNCE_CYC(0), .TOGGLE_CYC(4), .HOLD_CYC(8), .GAP_CYC(4)
    ) u_clean (
        .clk(clk), .rst(c_rst), .col(c_col), .row(c_row),
        .cmd_valid(c_valid), .cmd_key(c_key), .cmd_ready(c_ready),
        .contact(c_contact), .busy(c_busy), .done(c_done)
    );

    keypad_emulator #(
        .BOUNCE_CYC(20), .TOGGLE_CYC(4), .HOLD_CYC(8), .GAP_CYC(4)
    ) u_bnc (
        .clk(clk), .rst(b_rst), .col(b_col), .row(b_row),
        .cmd_valid(b_valid), .cmd_key(b_key), .cmd_ready(b_ready),
        .contact(b_contact), .busy(b_busy), .done(b_done)
    );

    typedef struct packed {
        logic       contact;
        logic [3:0] row;
        logic       done;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_chk  = 0;
    int         n_pass = 0;

    // key code -> row / column on the keypad
    int kr_tab[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int kc_tab[16] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 1};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        logic fb;
        fb = x[0] ^ x[2] ^ x[3] ^ x[5];
        return {fb, x[15:1]};
    endfunction

    // Present a command on the clean instance; returns in cycle 0 after accept.
    task automatic start_clean(input logic [3:0] key);
        int w;
        c_key   = key;
        c_valid = 1'b1;
        w = 0;
        while (!c_ready && w < 40) begin
            step();
            w++;
        end
        chk("ready_wait", {7'd0, c_ready}, 8'd1);
        step();
    endtask

    initial begin
        logic [15:0] lfsr;
        logic        cur;
        logic [3:0]  ecol;
        int          w;
        int          seen;

        c_rst = 1'b1; c_valid = 1'b0; c_key = 4'h0; c_col = 4'hF;
        b_rst = 1'b1; b_valid = 1'b0; b_key = 4'h0; b_col = 4'hF;
        step();
        step();
        chk("rst_row",     {4'd0, c_row}, 8'h0F);
        chk("rst_ready",   {7'd0, c_ready}, 8'd1);
        chk("rst_busy",    {7'd0, c_busy}, 8'd0);
        chk("rst_done",    {7'd0, c_done}, 8'd0);
        chk("rst_contact", {7'd0, c_contact}, 8'd0);
        c_rst = 1'b0;
        b_rst = 1'b0;
        step();

        // clean press of key 5, probing its own column and a foreign one
        for (int k = 0; k < 14; k++) begin
            e.contact = (k >= 1 && k <= 8);
            e.row     = e.contact ? 4'b1101 : 4'hF;
            e.done    = (k == 12);
            e.busy    = (k < 12);
            exp_q.push_back(e);
        end
        c_col = 4'b1101;
        start_clean(4'h5);
        c_valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) step();
            c_col = 4'b1101;
            #1;
            e = exp_q.pop_front();
            chk($sformatf("t1_contact[%0d]", k), {7'd0, c_contact}, {7'd0, e.contact});
            chk($sformatf("t1_row[%0d]", k), {4'd0, c_row}, {4'd0, e.row});
            chk($sformatf("t1_done[%0d]", k), {7'd0, c_done}, {7'd0, e.done});
            chk($sformatf("t1_busy[%0d]", k), {7'd0, c_busy}, {7'd0, e.busy});
            c_col = 4'b1110;
            #1;
            chk($sformatf("t1_row_other[%0d]", k), {4'd0, c_row}, 8'h0F);
        end

        // every key code, walking-zero column scan during the hold
        for (int key = 0; key < 16; key++) begin
            start_clean(4'(key));
            c_valid = 1'b0;
            step();
            step();
            for (int c = 0; c < 4; c++) begin
                e.contact = 1'b1;
                e.done    = 1'b0;
                e.busy    = 1'b1;
                ecol      = 4'b0001 << kr_tab[key];
                e.row     = (c == kc_tab[key]) ? ~ecol : 4'hF;
                exp_q.push_back(e);
                ecol  = 4'b0001 << c;
                c_col = ~ecol;
                #1;
                e = exp_q.pop_front();
                chk($sformatf("t2_row_k%0h_c%0d", key, c), {4'd0, c_row}, {4'd0, e.row});
            end
            w = 0;
            while (!c_done && w < 30) begin
                step();
                w++;
            end
            chk($sformatf("t2_done_k%0h", key), {7'd0, c_done}, 8'd1);
        end

        // back-to-back with cmd_valid held; key changes while busy are ignored
        c_col = 4'b1110;
        start_clean(4'h1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3)  c_key = 4'h9;
            if (k == 10) c_key = 4'h2;
            if (k <= 11) chk($sformatf("t4_ready[%0d]", k), {7'd0, c_ready}, 8'd0);
            if (k == 5) begin
                c_col = 4'b1110;
                #1;
                chk("t4_row_key1", {4'd0, c_row}, 8'h0E);
                c_col = 4'b1011;
                #1;
                chk("t4_row_not9", {4'd0, c_row}, 8'h0F);
            end
        end
        chk("t4_done",       {7'd0, c_done}, 8'd1);
        chk("t4_ready_done", {7'd0, c_ready}, 8'd1);
        step();
        c_valid = 1'b0;
        chk("t4_busy2",  {7'd0, c_busy}, 8'd1);
        chk("t4_ready2", {7'd0, c_ready}, 8'd0);
        step();
        c_col = 4'b1101;
        #1;
        chk("t4_row_key2", {4'd0, c_row}, 8'h0E);
        w = 0;
        while (!c_done && w < 30) begin
            step();
            w++;
        end
        chk("t4_done2", {7'd0, c_done}, 8'd1);
        step();

        // reset in the middle of HOLD
        c_col = 4'b1101;
        start_clean(4'h5);
        c_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t5_row_pre", {4'd0, c_row}, 8'h0D);
        c_rst = 1'b1;
        #1;
        chk("t5_row",     {4'd0, c_row}, 8'h0F);
        chk("t5_contact", {7'd0, c_contact}, 8'd0);
        chk("t5_busy",    {7'd0, c_busy}, 8'd0);
        chk("t5_ready",   {7'd0, c_ready}, 8'd1);
        step();
        c_rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (c_done || c_busy) seen++;
        end
        chk("t5_no_done", 8'(seen), 8'd0);

        // bouncing press of key 5 against the LFSR reference
        lfsr = 16'hACE1;
        cur  = 1'b0;
        for (int k = 0; k < 53; k++) begin
            if ((k >= 4 && k <= 20 && k % 4 == 0) || (k >= 32 && k <= 48 && k % 4 == 0)) begin
                cur  = lfsr[0];
                lfsr = lfsr_adv(lfsr);
            end else if (k >= 21 && k <= 28) begin
                cur = 1'b1;
            end else if (k >= 49) begin
                cur = 1'b0;
            end
            e.contact = cur;
            e.row     = cur ? 4'b1101 : 4'hF;
            e.done    = (k == 52);
            e.busy    = (k < 52);
            exp_q.push_back(e);
        end
        b_col   = 4'b1101;
        b_key   = 4'h5;
        b_valid = 1'b1;
        chk("t3_ready", {7'd0, b_ready}, 8'd1);
        step();
        b_valid = 1'b0;
        for (int k = 0; k < 53; k++) begin
            if (k > 0) step();
            #1;
            e = exp_q.pop_front();
            chk($sformatf("t3_contact[%0d]", k), {7'd0, b_contact}, {7'd0, e.contact});
            chk($sformatf("t3_row[%0d]", k), {4'd0, b_row}, {4'd0, e.row});
            chk($sformatf("t3_done[%0d]", k), {7'd0, b_done}, {7'd0, e.done});
            chk($sformatf("t3_busy[%0d]", k), {7'd0, b_busy}, {7'd0, e.busy});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
